// File: rtl/axil_fir_pkg.sv
// Shared constants and types for the AXI4-Lite FIR register block:
// register word indices, CTRL/STATUS bit positions, AXI response codes,
// the MAC engine state type and a byte-strobe merge helper.
package axil_fir_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_STATUS    = 1;
    localparam int REG_SAMPLE    = 2;
    localparam int REG_RESULT    = 3;
    localparam int REG_COEF_BASE = 4;

    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_SAT     = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_FIN  = 2'd2
    } fir_state_t;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_fir_regs_mac.sv
// Sequential FIR engine: delay line, one multiply-accumulate per cycle,
// saturation of the final sum to signed 32 bits and the sticky flags.
module fir_mac_core
    import axil_fir_pkg::*;
#(
    parameter int NUM_TAPS     = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           sample_we,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    input  logic signed [COEF_WIDTH-1:0]   coefs [NUM_TAPS],
    output logic                           busy,
    output logic                           done,
    output logic                           overrun,
    output logic                           sat,
    output logic [31:0]                    result,
    output logic signed [SAMPLE_WIDTH-1:0] newest
);

    localparam int K_W   = $clog2(NUM_TAPS);
    localparam int PRD_W = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int ACC_W = PRD_W + K_W;
    localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    fir_state_t                     state;
    logic [K_W-1:0]                 k;
    logic signed [SAMPLE_WIDTH-1:0] taps [NUM_TAPS];
    logic signed [ACC_W-1:0]        acc;
    logic signed [PRD_W-1:0]        prod;
    logic signed [63:0]             acc_ext;

    assign busy   = (state != ST_IDLE);
    assign newest = taps[0];

    // Current tap product and sign-extended accumulator for saturation.
    always_comb begin
        prod    = taps[k] * coefs[k];
        acc_ext = 64'(acc);
    end

    // FSM, delay line, accumulator and sticky flags.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            k       <= '0;
            acc     <= '0;
            result  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            sat     <= 1'b0;
            // NOTE: the delay line is reset explicitly because stale taps would leak into the first results.
            for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
        end else if (clear) begin
            state   <= ST_IDLE;
            k       <= '0;
            acc     <= '0;
            result  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            sat     <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
        end else begin
            if (sample_we && state != ST_IDLE) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (sample_we) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) taps[i] <= taps[i-1];
                        taps[0] <= sample;
                        acc     <= '0;
                        done    <= 1'b0;
                        k       <= '0;
                        state   <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == K_W'(NUM_TAPS - 1)) begin
                        state <= ST_FIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_FIN: begin
                    if (acc_ext > SAT_MAX) begin
                        result <= 32'h7FFF_FFFF;
                        sat    <= 1'b1;
                    end else if (acc_ext < SAT_MIN) begin
                        result <= 32'h8000_0000;
                        sat    <= 1'b1;
                    end else begin
                        result <= acc_ext[31:0];
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axil_fir_regs.sv
// AXI4-Lite register front end for the sequential FIR engine.
// Optional build macro FIR_IRQ_EN adds the irq output and CTRL.IRQ_ENABLE.
module axil_fir_regs
    import axil_fir_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int NUM_TAPS     = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY
`ifdef FIR_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int IDX_W    = ADDR_WIDTH - 2;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int NUM_REGS = REG_COEF_BASE + NUM_TAPS;

    logic                           aw_held, w_held, rd_en;
    logic [IDX_W-1:0]               wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]          w_data_q, rd_data;
    logic [STRB_W-1:0]              w_strb_q;
    logic [1:0]                     rd_resp;
    logic                           commit, wr_bad, clear, sample_we;
    logic signed [COEF_WIDTH-1:0]   coef [NUM_TAPS];
    logic                           busy, done, overrun, sat;
    logic [31:0]                    result;
    logic signed [SAMPLE_WIDTH-1:0] newest;
    logic                           unused_addr_bits;
`ifdef FIR_IRQ_EN
    logic                           irq_en;
`endif

    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign rd_idx           = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign commit           = aw_held & w_held;
    assign wr_bad           = int'(wr_idx) >= NUM_REGS;
    assign clear            = commit && int'(wr_idx) == REG_CTRL && w_strb_q[0]
                              && w_data_q[CTRL_CLEAR_BIT];
    assign sample_we        = commit && int'(wr_idx) == REG_SAMPLE && (|w_strb_q);
    assign S_AXI_ARREADY    = rd_en & ~S_AXI_RVALID;

    // Write channel: independent AW/W capture, commit, single B response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            wr_idx        <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
`ifdef FIR_IRQ_EN
            irq_en        <= 1'b0;
`endif
        end else begin
            S_AXI_AWREADY <= ~S_AXI_AWREADY & S_AXI_AWVALID & ~aw_held & ~S_AXI_BVALID;
            S_AXI_WREADY  <= ~S_AXI_WREADY & S_AXI_WVALID & ~w_held & ~S_AXI_BVALID;
            if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                aw_held <= 1'b1;
                wr_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (S_AXI_WREADY && S_AXI_WVALID) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_bad ? RESP_SLVERR : RESP_OKAY;
`ifdef FIR_IRQ_EN
                if (int'(wr_idx) == REG_CTRL && w_strb_q[0]) irq_en <= w_data_q[CTRL_IRQ_EN_BIT];
`endif
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Coefficient bank with per-byte strobes; writes land even while busy.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (int'(wr_idx) == REG_COEF_BASE + i)
                    coef[i] <= COEF_WIDTH'(apply_strb(32'(coef[i]), w_data_q, w_strb_q));
            end
        end
    end

    // Read decode for the address currently presented on AR.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (int'(rd_idx) >= NUM_REGS) begin
            rd_resp = RESP_SLVERR;
        end else if (int'(rd_idx) == REG_CTRL) begin
`ifdef FIR_IRQ_EN
            rd_data[CTRL_IRQ_EN_BIT] = irq_en;
`endif
        end else if (int'(rd_idx) == REG_STATUS) begin
            rd_data[STAT_BUSY]    = busy;
            rd_data[STAT_DONE]    = done;
            rd_data[STAT_OVERRUN] = overrun;
            rd_data[STAT_SAT]     = sat;
        end else if (int'(rd_idx) == REG_SAMPLE) begin
            rd_data = DATA_WIDTH'(newest);
        end else if (int'(rd_idx) == REG_RESULT) begin
            rd_data = result;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (int'(rd_idx) == REG_COEF_BASE + i) rd_data = DATA_WIDTH'(coef[i]);
            end
        end
    end

    // Read channel: registered data/response, held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_en        <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else begin
            rd_en <= 1'b1;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_resp;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

`ifdef FIR_IRQ_EN
    // Registered interrupt: follows DONE gated by IRQ_ENABLE.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) irq <= 1'b0;
        else        irq <= done & irq_en;
    end
`endif

    fir_mac_core #(
        .NUM_TAPS    (NUM_TAPS),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .COEF_WIDTH  (COEF_WIDTH)
    ) u_core (
        .clk      (ACLK),
        .rst      (ARESET),
        .clear    (clear),
        .sample_we(sample_we),
        .sample   (w_data_q[SAMPLE_WIDTH-1:0]),
        .coefs    (coef),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .sat      (sat),
        .result   (result),
        .newest   (newest)
    );

endmodule

// File: tb/tb_axil_fir_regs.sv
// Directed bench for axil_fir_regs: register access, handshake ordering,
// FIR arithmetic, saturation, overrun/clear and reset during MAC.
module tb_axil_fir_regs;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [5:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [5:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
`ifdef FIR_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int commit_cyc = 0;

    axil_fir_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
`ifdef FIR_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge ACLK);
    endtask

    // w_lag > 0: W follows AW by w_lag cycles; w_lag < 0: AW follows W.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lag, input bit take_b,
                             output logic [1:0] resp);
        int aw_start, w_start, cyc;
        bit aw_hs, w_hs, aw_done, w_done;
        aw_start = (w_lag < 0) ? -w_lag : 0;
        w_start  = (w_lag > 0) ? w_lag : 0;
        aw_hs = 0; w_hs = 0; aw_done = 0; w_done = 0; cyc = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; aw_hs = 0; end
            if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; w_hs  = 0; end
            if (!aw_done && !S_AXI_AWVALID && cyc >= aw_start) begin
                S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
            end
            if (!w_done && !S_AXI_WVALID && cyc >= w_start) begin
                S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_hs = 1;
            if (S_AXI_WVALID && S_AXI_WREADY)   w_hs  = 1;
            if (!(aw_done && w_done)) begin @(negedge ACLK); cyc++; end
        end
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL write_handshake addr=%h: got no AW/W handshake, expected one within 50 cycles", addr);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            return;
        end
        if (take_b) begin
            S_AXI_BREADY = 1'b1;
            cyc = 0;
            while (!S_AXI_BVALID && cyc < 20) begin @(negedge ACLK); cyc++; end
            if (!S_AXI_BVALID) begin
                checks++; errors++;
                $display("FAIL write_bvalid addr=%h: got BVALID=0, expected 1 within 20 cycles", addr);
            end else begin
                resp = S_AXI_BRESP;
                commit_cyc = cyc_cnt;
            end
            @(negedge ACLK);
            S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit ar_hs, got;
        data = 'x; resp = 'x; ar_hs = 0; got = 0; cyc = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        while (!got && cyc < 30) begin
            if (ar_hs) begin S_AXI_ARVALID = 1'b0; ar_hs = 0; end
            if (S_AXI_RVALID) begin
                data = S_AXI_RDATA; resp = S_AXI_RRESP; got = 1;
            end else begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) ar_hs = 1;
                @(negedge ACLK); cyc++;
            end
        end
        S_AXI_ARVALID = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h: got no RVALID, expected one within 30 cycles", addr);
        end
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        #2 ARESET = 1'b1;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
             S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, expected all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA);
        end
        wait_cycles(3);
        ARESET = 1'b0;
        wait_cycles(2);
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL reset_status: got %h/%b expected 00000000/00", d, r);
        end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", d); end
    endtask

    task automatic test_fir_basic();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 8; i++) axi_write(6'(16 + 4*i), 32'd1, 4'hF, 0, 1, r);
        for (int s = 1; s <= 8; s++) begin
            axi_write(6'h08, 32'(s), 4'hF, 0, 1, r);
            if (s < 8) wait_cycles(12);
        end
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL fir_busy_early: got %h expected 00000001", d); end
        while (cyc_cnt < commit_cyc + 8) @(negedge ACLK);
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL fir_busy_c8: got %h expected 00000001", d); end
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL fir_done: got %h expected 00000002", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h24) begin errors++; $display("FAIL fir_result: got %h expected 00000024", d); end
    endtask

    task automatic test_handshake_order();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h14, 32'h0000_1234, 4'hF, 3, 1, r);
        checks++;
        if (r !== 2'b00 || S_AXI_BVALID !== 1'b0) begin
            errors++; $display("FAIL aw_first_b: got bresp=%b bvalid=%b expected 00/0", r, S_AXI_BVALID);
        end
        axi_write(6'h18, 32'hFFFF_8001, 4'hF, -3, 1, r);
        wait_cycles(2);
        checks++;
        if (r !== 2'b00 || S_AXI_BVALID !== 1'b0) begin
            errors++; $display("FAIL w_first_b: got bresp=%b bvalid=%b expected 00/0", r, S_AXI_BVALID);
        end
        axi_read(6'h14, d, r);
        checks++;
        if (d !== 32'h0000_1234) begin errors++; $display("FAIL aw_first_data: got %h expected 00001234", d); end
        axi_read(6'h18, d, r);
        checks++;
        if (d !== 32'hFFFF_8001) begin errors++; $display("FAIL w_first_signext: got %h expected ffff8001", d); end
        axi_write(6'h1C, 32'hAAAA_AA55, 4'b0001, 0, 1, r);
        axi_read(6'h1C, d, r);
        checks++;
        if (d !== 32'h0000_0055) begin errors++; $display("FAIL wstrb_byte0: got %h expected 00000055", d); end
    endtask

    task automatic test_decode_errors();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h30, 32'h1234_5678, 4'hF, 0, 1, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL slverr_write: got %b expected 10", r); end
        axi_read(6'h30, d, r);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            errors++; $display("FAIL slverr_read: got %h/%b expected 00000000/10", d, r);
        end
        axi_read(6'h2C, d, r);
        checks++;
        if (r !== 2'b00 || d !== 32'h1) begin
            errors++; $display("FAIL last_coef_read: got %h/%b expected 00000001/00", d, r);
        end
        axi_write(6'h0C, 32'hDEAD_BEEF, 4'hF, 0, 1, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL ro_write_resp: got %b expected 00", r); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h24) begin errors++; $display("FAIL ro_unchanged: got %h expected 00000024", d); end
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL sample_readback: got %h expected 00000008", d); end
        axi_read(6'h00, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h expected 00000000", d); end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 8; i++) axi_write(6'(16 + 4*i), 32'h7FFF, 4'hF, 0, 1, r);
        for (int s = 0; s < 8; s++) begin
            axi_write(6'h08, 32'h7FFF, 4'hF, 0, 1, r);
            wait_cycles(12);
        end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_result: got %h expected 7fffffff", d); end
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'hA) begin errors++; $display("FAIL sat_status: got %h expected 0000000a", d); end
    endtask

    task automatic test_overrun_clear();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h00, 32'h2, 4'hF, 0, 1, r);
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL clear1_status: got %h expected 00000000", d); end
        axi_write(6'h10, 32'h2, 4'hF, 0, 1, r);
        axi_write(6'h08, 32'h5, 4'hF, 0, 1, r);
        axi_write(6'h08, 32'h7, 4'hF, 0, 1, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL overrun_resp: got %b expected 00", r); end
        wait_cycles(15);
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL overrun_status: got %h expected 00000006", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'hA) begin errors++; $display("FAIL overrun_result: got %h expected 0000000a", d); end
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL overrun_sample: got %h expected 00000005", d); end
        axi_write(6'h00, 32'h2, 4'hF, 0, 1, r);
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL clear2_status: got %h expected 00000000", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL clear2_result: got %h expected 00000000", d); end
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL clear_keeps_coef: got %h expected 00000002", d); end
    endtask

    task automatic test_reset_mid_mac();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h08, 32'h1, 4'hF, 0, 0, r);
        wait_cycles(3);
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL pending_bvalid: got %b expected 1", S_AXI_BVALID); end
        #2 ARESET = 1'b1;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
             S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== 40'h0) begin
            errors++;
            $display("FAIL midmac_reset_outputs: got b=%b ar=%b r=%b rdata=%h, expected all 0",
                     S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA);
        end
        wait_cycles(2);
        ARESET = 1'b0;
        wait_cycles(2);
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midmac_status: got %h expected 00000000", d); end
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midmac_coef0: got %h expected 00000000", d); end
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL midmac_no_b: got %b expected 0", S_AXI_BVALID); end
    endtask

    initial begin
        test_reset();
        test_fir_basic();
        test_handshake_order();
        test_decode_errors();
        test_saturation();
        test_overrun_clear();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_fir_regs.md
Name: axil_fir_regs

Overview:
- Parametrised AXI4-Lite slave that is the next generation of the team's 4-register filter IP.
- Register count scales with the number of filter taps.
- A sequential multiply-accumulate FIR engine is started by each sample written over the bus.
- Sits behind the block-design AXI interconnect; driven by the master VIP agent in simulation and by the PS in hardware.

Parameters:
- DATA_WIDTH, 32, AXI data width and RESULT width; only 32 is supported.
- ADDR_WIDTH, 6, AXI byte-address width; must satisfy 2^ADDR_WIDTH >= 4*(4+NUM_TAPS).
- NUM_TAPS, 8, number of FIR taps (2..16).
- SAMPLE_WIDTH, 16, signed sample width, taken from SAMPLE_IN[SAMPLE_WIDTH-1:0].
- COEF_WIDTH, 16, signed coefficient width, taken from COEFn[COEF_WIDTH-1:0].

Ports:
- ACLK  in  1  single clock.
- ARESET  in  1  asynchronous reset, active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all READY/VALID outputs 0, RESP 0, RDATA 0; all registers, delay line, accumulator and FSM cleared. Reset mid-transaction drops the transaction; no response is issued.
- Register map (word index = addr[ADDR_WIDTH-1:2]):
  - 0 CTRL (RW): bit1 CLEAR is self-clearing; other bits reserved, read 0.
  - 1 STATUS (RO):
    - bit0 BUSY.
    - bit1 DONE, sticky.
    - bit2 OVERRUN, sticky.
    - bit3 SAT, sticky.
  - 2 SAMPLE_IN (WO; reads return the last accepted sample, sign-extended).
  - 3 RESULT (RO).
  - 4..4+NUM_TAPS-1: COEF0..COEF(NUM_TAPS-1) (RW, sign-extended on read).
- Write channel:
  - AW and W are accepted independently, in either order; each READY pulses for one cycle on its handshake.
  - The register is updated in the cycle both are held; BVALID rises the next cycle and holds until BREADY.
  - No new AW/W is accepted while BVALID=1.
  - WSTRB applies per byte to RW registers. A SAMPLE_IN write with any WSTRB bit set counts as a sample write.
- Read channel:
  - ARREADY=1 when RVALID=0.
  - RDATA/RRESP are registered and RVALID rises one cycle after the AR handshake, holding until RREADY.
  - Reads and writes proceed concurrently.
- Responses:
  - Word index >= 4+NUM_TAPS returns SLVERR (2'b10); writes are ignored and reads return 0.
  - Writes to RO registers return OKAY and are ignored.
- FSM states IDLE -> MAC -> FIN -> IDLE:
  - IDLE: a SAMPLE_IN write shifts the delay line (tap0 = newest, oldest discarded), clears the accumulator and DONE, then moves to MAC.
  - MAC: one product coef[k]*tap[k] per cycle for k=0..NUM_TAPS-1, then FIN.
  - FIN: the accumulator is saturated to signed 32 bits into RESULT; SAT is set if clipped; DONE is set; return to IDLE.
  - BUSY = state!=IDLE. Latency is NUM_TAPS+1 cycles from the write-commit cycle to DONE.
- Accumulator width is SAMPLE_WIDTH+COEF_WIDTH+clog2(NUM_TAPS), signed.
- SAMPLE_IN write while BUSY: the sample is dropped, OVERRUN is set, response is OKAY.
- Coefficient write while BUSY: takes effect immediately; the result is then undefined but must not hang.
- CLEAR=1 write:
  - Aborts MAC (return to IDLE, DONE not set) and zeroes the delay line, accumulator, RESULT and all sticky bits.
  - Coefficients are kept.
  - CLEAR coinciding with the FIN cycle: CLEAR wins.

Optional Feature:
- Macro FIR_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit, reset 0).
  - CTRL bit2 becomes IRQ_ENABLE (RW).
  - irq is registered and equals DONE & IRQ_ENABLE; it deasserts one cycle after DONE clears.
- When undefined: no irq port; CTRL bit2 is reserved and reads 0.

Decomposition:
- Package axil_fir_pkg holds:
  - Register index constants (REG_CTRL, REG_STATUS, REG_SAMPLE, REG_RESULT, REG_COEF_BASE).
  - STATUS bit positions.
  - The RESP_OKAY/RESP_SLVERR constants.
  - The FSM state enum typedef.
- One sub-module, fir_mac_core, holds the delay line, accumulator, FSM and saturation. The top level keeps the AXI handshake logic and register decode.

Test Plan:
1. Write COEF0..7=1, then samples 1..8 to 0x08 → after the last write STATUS reads BUSY=1, then DONE=1 by 9 cycles after commit; RESULT=0x24.
2. AW issued 3 cycles before W, and separately W before AW → exactly one BVALID per write with BRESP=0; register contents correct.
3. Read/write 0x30 → BRESP/RRESP=2'b10 and RDATA=0; the write to RO 0x0C returns OKAY and RESULT is unchanged.
4. All COEF=0x7FFF, eight samples 0x7FFF → RESULT=0x7FFFFFFF and STATUS.SAT=1.
5. Second sample written 2 cycles after the first → STATUS.OVERRUN=1; RESULT reflects the first sample only. Then CLEAR → STATUS=0 and RESULT=0.
6. ARESET asserted during MAC with BVALID pending → all outputs 0 immediately; after release, STATUS=0 and COEF0 reads 0.
